skew_gen_ctrl: RTL and testbench

Sequencer that programs the per-lane skew of the channel model's `skew_gen_fifo` array (one FIFO per PCS lane). It:
- latches a skew vector from the register file and range-checks it;
- waits for an alignment-marker boundary on the reference lane;
- issues one `rf_update` per lane on a shared skew bus;
- waits for the FIFOs to flush, then reports done.

It sits between the register file and the `N_LANES` skew FIFO instances.

---
 rtl/skew_gen_pkg.sv | 30 +++
 rtl/skew_gen_lfsr.sv | 28 ++
 rtl/skew_gen_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_skew_gen_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/skew_gen_pkg.sv
// -----------------------------------------------------------------------------
// skew_gen_pkg
// Shared definitions for the skew generator control slice:
//   - FSM state encodings of skew_gen_ctrl (also visible on its o_state port)
//   - LFSR width, tap mask and seed used by skew_gen_lfsr
//   - default range limit and marker timeout of skew_gen_ctrl
// -----------------------------------------------------------------------------
package skew_gen_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CHECK   = 3'd1;
  localparam logic [2:0] ST_WAIT_AM = 3'd2;
  localparam logic [2:0] ST_UPDATE  = 3'd3;
  localparam logic [2:0] ST_FLUSH   = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

  // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1:
  // feedback is the XOR of bits 0, 2, 3 and 5, inserted at bit 15.
  localparam int                LFSR_W    = 16;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'h002D;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;

  localparam int DEFAULT_SKEW_LIMIT = 15;
  localparam int DEFAULT_AM_TIMEOUT = 32768;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
    return {^(cur & LFSR_TAPS), cur[LFSR_W-1:1]};
  endfunction

endpackage

// File: rtl/skew_gen_lfsr.sv
// -----------------------------------------------------------------------------
// skew_gen_lfsr
// 16-bit Fibonacci LFSR supplying pseudo-random lane skews. Only instantiated
// by skew_gen_ctrl when SKEW_GEN_CTRL_RANDOM_EN is defined.
// Ports:
//   i_clock   - clock
//   i_reset_n - asynchronous active-low reset, loads LFSR_SEED
//   i_step    - advance one step on this edge
//   o_state   - current LFSR contents
// -----------------------------------------------------------------------------
module skew_gen_lfsr
  import skew_gen_pkg::*;
(
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic              i_step,
  output logic [LFSR_W-1:0] o_state
);

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_state <= LFSR_SEED;
    end else if (i_step) begin
      o_state <= lfsr_next(o_state);
    end
  end

endmodule

// File: rtl/skew_gen_ctrl.sv
// -----------------------------------------------------------------------------
// skew_gen_ctrl
// Programs the per-lane skew of the skew_gen_fifo array: latches a skew
// vector, range-checks it, waits for an alignment marker on the reference
// lane, strobes each lane once on a shared skew bus, waits for the FIFOs to
// flush and then pulses o_done.
//
// Optional feature: define SKEW_GEN_CTRL_RANDOM_EN to build an LFSR; a start
// with i_cfg_random high then takes skews from the LFSR (clamped to
// SKEW_LIMIT) instead of i_cfg_skew. Without the macro i_cfg_random is unused.
//
// Ports:
//   i_clock, i_reset_n   - clock, asynchronous active-low reset
//   i_enable             - clock enable; low freezes all state
//   i_valid              - block valid of the reference lane
//   i_aligner_tag        - alignment-marker tag of the reference lane
//   i_cfg_start          - one-cycle request to apply i_cfg_skew
//   i_cfg_skew           - packed lane skews, lane k at [k*NB +: NB]
//   i_cfg_random         - select LFSR skews (macro builds only)
//   o_rf_update          - one-hot update strobe to the lane FIFOs
//   o_rf_skew            - skew for the strobed lane
//   o_busy               - high in every state except IDLE
//   o_done               - one-cycle completion pulse
//   o_cfg_error          - one-cycle error pulse
//   o_state              - current FSM state (skew_gen_pkg encodings)
//
// Strobe semantics: a lane FIFO takes o_rf_skew on any cycle where its
// o_rf_update bit is high; there is no back-pressure. Because o_rf_update is
// gated by i_enable and state only advances when i_enable is high, every lane
// sees exactly one accepted strobe per sequence.
// -----------------------------------------------------------------------------
module skew_gen_ctrl
  import skew_gen_pkg::*;
#(
  parameter int N_LANES        = 20,
  parameter int MAX_SKEW       = 16,
  parameter int NB_SKEW_SELECT = $clog2(MAX_SKEW),
  parameter int SKEW_LIMIT     = DEFAULT_SKEW_LIMIT,
  parameter int FIFO_DEPTH     = 20,
  parameter int AM_TIMEOUT     = DEFAULT_AM_TIMEOUT
) (
  input  logic                              i_clock,
  input  logic                              i_reset_n,
  input  logic                              i_enable,
  input  logic                              i_valid,
  input  logic                              i_aligner_tag,
  input  logic                              i_cfg_start,
  input  logic [N_LANES*NB_SKEW_SELECT-1:0] i_cfg_skew,
  input  logic                              i_cfg_random,
  output logic [N_LANES-1:0]                o_rf_update,
  output logic [NB_SKEW_SELECT-1:0]         o_rf_skew,
  output logic                              o_busy,
  output logic                              o_done,
  output logic                              o_cfg_error,
  output logic [2:0]                        o_state
);

  localparam int LW = $clog2(N_LANES + 1);
  localparam int TW = $clog2(AM_TIMEOUT + 1);
  localparam int FW = $clog2(FIFO_DEPTH + 1);

  localparam logic [LW-1:0] LANE_LAST  = LW'(N_LANES - 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(AM_TIMEOUT - 1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(FIFO_DEPTH - 1);
  localparam logic [31:0]   LIMIT_U    = 32'(SKEW_LIMIT);

  logic [2:0]                state;
  logic [LW-1:0]             lane_cnt;
  logic [TW-1:0]             timer;
  logic [FW-1:0]             flush_cnt;
  logic [NB_SKEW_SELECT-1:0] shadow [N_LANES];
  logic                      err_q;
  logic                      rand_q;
  logic                      cfg_random;
  logic                      range_err;
  logic [NB_SKEW_SELECT-1:0] skew_sel;
  logic [N_LANES-1:0]        lane_onehot;

`ifdef SKEW_GEN_CTRL_RANDOM_EN
  localparam logic [NB_SKEW_SELECT-1:0] LIMIT_V = NB_SKEW_SELECT'(SKEW_LIMIT);

  logic [LFSR_W-1:0] lfsr_q;
  logic              lfsr_step;

  assign cfg_random = i_cfg_random;
  // One step per accepted UPDATE cycle, so lane k always gets the k-th value.
  assign lfsr_step  = i_enable && rand_q && (state == ST_UPDATE);

  skew_gen_lfsr u_lfsr (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .i_step    (lfsr_step),
    .o_state   (lfsr_q)
  );

  wire unused_lfsr_hi = ^lfsr_q[LFSR_W-1:NB_SKEW_SELECT];
`else
  assign cfg_random = 1'b0;
  wire unused_cfg_random = i_cfg_random;
`endif

  // Any shadow lane above the limit rejects the whole vector; random mode
  // produces only clamped values and therefore always passes.
  always_comb begin
    range_err = 1'b0;
    for (int i = 0; i < N_LANES; i++) begin
      if (32'(shadow[i]) > LIMIT_U) range_err = 1'b1;
    end
    if (rand_q) range_err = 1'b0;
  end

  always_comb begin
    skew_sel = shadow[lane_cnt];
`ifdef SKEW_GEN_CTRL_RANDOM_EN
    if (rand_q) begin
      skew_sel = (lfsr_q[NB_SKEW_SELECT-1:0] > LIMIT_V) ? LIMIT_V
                                                        : lfsr_q[NB_SKEW_SELECT-1:0];
    end
`endif
  end

  assign lane_onehot = N_LANES'(1) << lane_cnt;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state     <= ST_IDLE;
      lane_cnt  <= '0;
      timer     <= '0;
      flush_cnt <= '0;
      err_q     <= 1'b0;
      rand_q    <= 1'b0;
      for (int i = 0; i < N_LANES; i++) shadow[i] <= '0;
    end else if (i_enable) begin
      // err_q is a pulse: it lives for one enabled cycle, and is held while
      // i_enable is low so a pending error is not lost.
      err_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          lane_cnt  <= '0;
          timer     <= '0;
          flush_cnt <= '0;
          if (i_cfg_start) begin
            for (int i = 0; i < N_LANES; i++) begin
              shadow[i] <= i_cfg_skew[i*NB_SKEW_SELECT +: NB_SKEW_SELECT];
            end
            rand_q <= cfg_random;
            state  <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (range_err) begin
            err_q <= 1'b1;
            state <= ST_IDLE;
          end else begin
            state <= ST_WAIT_AM;
          end
        end
        ST_WAIT_AM: begin
          // A marker on the last timeout cycle still wins.
          if (i_valid && i_aligner_tag) begin
            state <= ST_UPDATE;
          end else if (timer == TIMER_LAST) begin
            err_q <= 1'b1;
            state <= ST_IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_UPDATE: begin
          if (lane_cnt == LANE_LAST) begin
            lane_cnt <= '0;
            state    <= ST_FLUSH;
          end else begin
            lane_cnt <= lane_cnt + 1'b1;
          end
        end
        ST_FLUSH: begin
          if (i_valid) begin
            if (flush_cnt == FLUSH_LAST) state <= ST_DONE;
            else flush_cnt <= flush_cnt + 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
      // A start while busy is refused without disturbing the sequence.
      if (i_cfg_start && (state != ST_IDLE)) err_q <= 1'b1;
    end
  end

  assign o_state     = state;
  assign o_busy      = (state != ST_IDLE);
  assign o_rf_update = (i_enable && (state == ST_UPDATE)) ? lane_onehot : '0;
  assign o_rf_skew   = (state == ST_UPDATE) ? skew_sel : '0;
  assign o_done      = i_enable && (state == ST_DONE);
  assign o_cfg_error = i_enable && err_q;

endmodule

// File: tb/tb_skew_gen_ctrl.sv
// -----------------------------------------------------------------------------
// tb_skew_gen_ctrl
// Directed bench for skew_gen_ctrl. A second instance with SKEW_LIMIT=7
// covers range rejection and the limit boundary.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_skew_gen_ctrl;
  import skew_gen_pkg::*;

  localparam int N   = 20;
  localparam int NB  = 4;
  localparam int FD  = 20;
  localparam int AMT = 32768;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          enable = 1'b1;
  logic          valid = 1'b1;
  logic          tag = 1'b0;
  logic          start = 1'b0;
  logic          start_lim = 1'b0;
  logic          random = 1'b0;
  logic [N*NB-1:0] cfg_skew = '0;

  logic [N-1:0]  upd, upd_lim;
  logic [NB-1:0] skew, skew_lim;
  logic          busy, busy_lim, done, done_lim, err, err_lim;
  logic [2:0]    st, st_lim;

  skew_gen_ctrl dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_enable(enable), .i_valid(valid),
    .i_aligner_tag(tag), .i_cfg_start(start), .i_cfg_skew(cfg_skew),
    .i_cfg_random(random), .o_rf_update(upd), .o_rf_skew(skew),
    .o_busy(busy), .o_done(done), .o_cfg_error(err), .o_state(st)
  );

  skew_gen_ctrl #(.SKEW_LIMIT(7)) dut_lim (
    .i_clock(clk), .i_reset_n(rst_n), .i_enable(enable), .i_valid(valid),
    .i_aligner_tag(1'b0), .i_cfg_start(start_lim), .i_cfg_skew(cfg_skew),
    .i_cfg_random(1'b0), .o_rf_update(upd_lim), .o_rf_skew(skew_lim),
    .o_busy(busy_lim), .o_done(done_lim), .o_cfg_error(err_lim), .o_state(st_lim)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [NB-1:0] exp_q[$];

  int strobe_cnt = 0;
  int lim_strobe_cnt = 0;
  int multi_hot = 0;

  always @(negedge clk) begin
    strobe_cnt     = strobe_cnt + $countones(upd);
    lim_strobe_cnt = lim_strobe_cnt + $countones(upd_lim);
    if ($countones(upd) > 1 || $countones(upd_lim) > 1) multi_hot = multi_hot + 1;
  end

  task automatic chk(input string tag_s, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag_s, obs, exp_v);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: k mod 16, mode 1: (3k+1) mod 16, mode 2: (k+5) mod 16
  task automatic load(input int mode);
    int v;
    for (int k = 0; k < N; k++) begin
      v = (mode == 0) ? (k % 16) : (mode == 1) ? ((3 * k + 1) % 16) : ((k + 5) % 16);
      cfg_skew[k*NB +: NB] = 4'(v);
      exp_q.push_back(4'(v));
    end
  endtask

  // Full sequence; marker presented mdelay cycles after the start edge.
  task automatic run_seq(input int mdelay);
    int base;
    int dcount;
    base = strobe_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    #1;
    chk("seq_check_state", 32'(st), 32'(ST_CHECK));
    chk("seq_check_busy", 32'(busy), 32'd1);
    tick();
    chk("seq_wait_state", 32'(st), 32'(ST_WAIT_AM));
    chk("seq_wait_err", 32'(err), 32'd0);
    for (int c = 2; c < mdelay; c++) tick();
    tag = 1'b1;
    tick();
    tag = 1'b0;
    for (int k = 0; k < N; k++) begin
      #1;
      chk("seq_upd", 32'(upd), 32'(1) << k);
      chk("seq_skew", 32'(skew), 32'(exp_q.pop_front()));
      tick();
    end
    dcount = 0;
    for (int j = 0; j < FD; j++) begin
      dcount += int'(done);
      tick();
    end
    chk("seq_flush_no_done", 32'(dcount), 32'd0);
    chk("seq_done", 32'(done), 32'd1);
    tick();
    chk("seq_done_pulse", 32'(done), 32'd0);
    chk("seq_idle_busy", 32'(busy), 32'd0);
    chk("seq_strobes", 32'(strobe_cnt - base), 32'(N));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int base;
    int dcount;
`ifdef SKEW_GEN_CTRL_RANDOM_EN
    logic [15:0]   g;
    logic [NB-1:0] v;
`endif

    // reset state
    repeat (2) tick();
    chk("rst_upd", 32'(upd), 32'd0);
    chk("rst_skew", 32'(skew), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_state", 32'(st), 32'(ST_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // A: skews k mod 16, marker 10 cycles after start
    load(0);
    run_seq(10);

    // B: lane 5 = 9 against limit 7 -> rejected at t+2
    cfg_skew = '0;
    cfg_skew[5*NB +: NB] = 4'd9;
    base = lim_strobe_cnt;
    start_lim = 1'b1;
    tick();
    start_lim = 1'b0;
    #1;
    chk("lim_check_state", 32'(st_lim), 32'(ST_CHECK));
    chk("lim_check_err", 32'(err_lim), 32'd0);
    tick();
    chk("lim_err", 32'(err_lim), 32'd1);
    chk("lim_err_busy", 32'(busy_lim), 32'd0);
    chk("lim_err_state", 32'(st_lim), 32'(ST_IDLE));
    tick();
    chk("lim_err_pulse", 32'(err_lim), 32'd0);
    chk("lim_no_strobes", 32'(lim_strobe_cnt - base), 32'd0);
    // every lane exactly at the limit is accepted
    for (int k = 0; k < N; k++) cfg_skew[k*NB +: NB] = 4'd7;
    start_lim = 1'b1;
    tick();
    start_lim = 1'b0;
    tick();
    chk("lim_edge_err", 32'(err_lim), 32'd0);
    chk("lim_edge_state", 32'(st_lim), 32'(ST_WAIT_AM));

    // C: no marker -> timeout error after AMT cycles in WAIT_AM
    base = strobe_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("to_wait_state", 32'(st), 32'(ST_WAIT_AM));
    for (int c = 0; c < AMT - 1; c++) tick();
    chk("to_last_busy", 32'(busy), 32'd1);
    chk("to_last_err", 32'(err), 32'd0);
    tick();
    chk("to_err", 32'(err), 32'd1);
    chk("to_busy", 32'(busy), 32'd0);
    tick();
    chk("to_err_pulse", 32'(err), 32'd0);
    chk("to_no_strobes", 32'(strobe_cnt - base), 32'd0);

    // D: start while busy, enable stalls, valid gaps in flush, held DONE
    exp_q.delete();
    load(1);
    base = strobe_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tag = 1'b1;  // marker on the first WAIT_AM cycle
    tick();
    tag = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (k == 4) begin
        start = 1'b0;
        enable = 1'b0;
        #1;
        chk("held_err", 32'(err), 32'd0);
        chk("held_upd", 32'(upd), 32'd0);
        tick();
        enable = 1'b1;
        #1;
        chk("busy_start_err", 32'(err), 32'd1);
      end
      if (k == 8) begin
        enable = 1'b0;
        for (int s = 0; s < 3; s++) begin
          #1;
          chk("stall_upd", 32'(upd), 32'd0);
          chk("stall_state", 32'(st), 32'(ST_UPDATE));
          tick();
        end
        enable = 1'b1;
      end
      #1;
      if (k == 5) chk("busy_err_pulse", 32'(err), 32'd0);
      chk("d_upd", 32'(upd), 32'(1) << k);
      chk("d_skew", 32'(skew), 32'(exp_q.pop_front()));
      if (k == 3) begin
        start = 1'b1;
        cfg_skew = '1;
      end
      tick();
    end
    dcount = 0;
    for (int j = 0; j < FD + 2; j++) begin
      valid = (j == 5 || j == 6) ? 1'b0 : 1'b1;
      #1;
      dcount += int'(done);
      tick();
    end
    valid = 1'b1;
    chk("d_flush_no_done", 32'(dcount), 32'd0);
    enable = 1'b0;
    #1;
    chk("d_done_held", 32'(done), 32'd0);
    chk("d_done_state", 32'(st), 32'(ST_DONE));
    tick();
    chk("d_done_held2", 32'(st), 32'(ST_DONE));
    enable = 1'b1;
    #1;
    chk("d_done", 32'(done), 32'd1);
    tick();
    chk("d_done_pulse", 32'(done), 32'd0);
    chk("d_idle_busy", 32'(busy), 32'd0);
    chk("d_strobes", 32'(strobe_cnt - base), 32'(N));

    // E: reset at lane 7, then a fresh sequence completes
    exp_q.delete();
    load(2);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tag = 1'b1;
    tick();
    tag = 1'b0;
    repeat (7) tick();
    chk("e_lane7", 32'(upd), 32'(1) << 7);
    #2;
    rst_n = 1'b0;
    #1;
    chk("e_rst_upd", 32'(upd), 32'd0);
    chk("e_rst_skew", 32'(skew), 32'd0);
    chk("e_rst_busy", 32'(busy), 32'd0);
    chk("e_rst_state", 32'(st), 32'(ST_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    exp_q.delete();
    load(2);
    run_seq(5);

`ifdef SKEW_GEN_CTRL_RANDOM_EN
    // F: random skews against a golden LFSR model
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    exp_q.delete();
    g = 16'hACE1;
    for (int k = 0; k < N; k++) begin
      v = g[3:0];
      exp_q.push_back(v);  // limit 15 covers every 4-bit value
      g = {g[0] ^ g[2] ^ g[3] ^ g[5], g[15:1]};
    end
    cfg_skew = '1;
    random = 1'b1;
    run_seq(3);
    random = 1'b0;
`endif

    chk("never_multi_hot", 32'(multi_hot), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
